tri_setup_sched: RTL and testbench
==================================

Name: tri_setup_sched

Overview:
- Frame-synchronous triangle setup scheduler sitting between the host/CPU-side triangle writer and `rasterizer`.
- Collects triangles into a staging list. On a committed frame boundary it sequences edge-coefficient setup (A, B, C per edge) through one shared multiplier into the active table.
- The rasterizer reads the active table by index while scanning.
- Setup runs during vertical blanking, so the active table never changes mid-scan.

Parameters:
- MAX_TRIS, 8, depth of the staging and active tables.
- IDX_W, $clog2(MAX_TRIS), index width.
- CNT_W, $clog2(MAX_TRIS+1), count width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame  in  1  one-cycle pulse from vga_timing at start of vertical blanking
- wr_valid  in  1  host triangle write request
- wr_ready  out  1  staging slot free and scheduler idle
- wr_x0, wr_y0, wr_x1, wr_y1, wr_x2, wr_y2  in  10 each  unsigned vertex coordinates
- wr_color  in  12  {r4, g4, b4}
- commit  in  1  pulse: mark the staging list for transfer at the next frame
- clear  in  1  pulse: empty the staging list and drop a pending commit
- rd_idx  in  IDX_W  rasterizer read index
- rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2  out  11 signed  edge A/B coefficients for edges AB, BC, CA
- rd_c0, rd_c1, rd_c2  out  22 signed  edge C constants
- rd_color  out  12  color of entry rd_idx
- tri_count  out  CNT_W  valid entries in the active table
- active_valid  out  1  active table is stable and readable
- setup_done  out  1  one-cycle pulse when setup completes
- frame_overrun  out  1  sticky; set when a frame arrives while busy

Behaviour:
- Reset values:
  - tri_count=0; active_valid=0; setup_done=0; frame_overrun=0.
  - Staging count=0; commit_pending=0; state=IDLE.
  - rd_* outputs are don't-care until active_valid=1.
- Edge function convention: E(x,y)=A*x+B*y+C. For edge (a→b): A=ya−yb, B=xb−xa, C=xa*yb−xb*ya.
  - Subtractions use 11-bit signed arithmetic.
  - Products are 20-bit unsigned, zero-extended to 22-bit signed before the subtract. No saturation is needed; |C| ≤ 1,046,529.
- Host writes:
  - wr_ready = (state==IDLE) && (stg_count<MAX_TRIS).
  - When wr_valid && wr_ready, the entry is stored at stg[stg_count] and stg_count increments on the same edge.
- clear has priority over a same-cycle write and over commit: stg_count←0 and commit_pending←0.
  - clear is ignored while not IDLE.
- commit sets commit_pending. A second commit before the frame has no extra effect.
- FSM states: IDLE, EDGE_P, EDGE_C, NEXT, FINISH.
- IDLE:
  - On frame && commit_pending: active_valid←0, tri_idx←0, edge←0, and go to EDGE_P (or FINISH if stg_count==0).
  - On frame without commit_pending: no action; the active table is retained.
- EDGE_P: multiplier computes xa*yb into product register p; go to EDGE_C.
- EDGE_C:
  - Multiplier computes xb*ya.
  - Write A, B and C=p−product into active[tri_idx] for the current edge.
  - If edge<2: edge++ and go to EDGE_P. Otherwise go to NEXT.
- NEXT:
  - Copy color to active[tri_idx].
  - If tri_idx==stg_count−1, go to FINISH. Otherwise tri_idx++, edge←0, and go to EDGE_P.
- FINISH:
  - tri_count←stg_count; active_valid←1; setup_done←1 for one cycle; commit_pending←0.
  - Staging is retained, so re-commit replays it. Go to IDLE.
- Latency: from the frame edge, setup_done is asserted 7*N+1 cycles later for N≥1, and 1 cycle later for N=0.
- Simultaneous events:
  - A frame while not IDLE sets frame_overrun; the in-progress setup continues unaffected.
  - A commit while busy is registered and applies at the next frame.
- rd_* outputs are combinational from active[rd_idx]. rd_idx≥tri_count returns stale data; the rasterizer must gate on tri_count.
- rst mid-setup returns all registers to their reset values. The active table contents are don't-care.

Decomposition:
- Package raster_pkg holds:
  - typedef vertex_t {x,y 10b}
  - tri_t {v0,v1,v2, color}
  - edge_t {a,b 11b signed; c 22b signed}
  - state enum
  - constants COORD_W=10, EDGE_W=22
- One sub-module, edge_setup_dp: shared 10x10 multiplier, p register, and A/B/C subtractors, selected by the edge index.

Test Plan:
1. Reset, then frame without any commit → tri_count=0, active_valid=0, no setup_done.
2. Write (100,100),(300,100),(200,300) color 0xF00, commit, frame → setup_done 8 cycles after frame. Expected entry 0:
   - edge0 A=0, B=200, C=−20000
   - edge1 A=−200, B=−100, C=70000
   - edge2 A=200, B=−100, C=−10000
   - color 0xF00, tri_count=1
3. Write 8 triangles; wr_ready must drop after the 8th. A 9th wr_valid is not accepted. Commit+frame → setup_done at 57 cycles, tri_count=8.
4. Frame pulse at cycle 3 of setup → frame_overrun=1 (sticky), results identical to scenario 2.
5. Clear in the same cycle as wr_valid and commit, then frame → no setup; stg_count=0; previous active table and tri_count retained.
6. Vertices (1023,0),(0,1023),(0,0) → edge0 C=1,046,529 with no overflow. Assert rst at cycle 4 of setup → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and widths for triangle setup: vertices, staged triangles,
// edge coefficient triples and the scheduler state encoding.
package raster_pkg;
  localparam int COORD_W = 10;
  localparam int EDGE_W  = 22;
  localparam int AB_W    = 11;
  localparam int COLOR_W = 12;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;

  typedef struct packed {
    vertex_t            v0;
    vertex_t            v1;
    vertex_t            v2;
    logic [COLOR_W-1:0] color;
  } tri_t;

  typedef struct packed {
    logic signed [AB_W-1:0]   a;
    logic signed [AB_W-1:0]   b;
    logic signed [EDGE_W-1:0] c;
  } edge_t;

  typedef enum logic [2:0] {IDLE, EDGE_P, EDGE_C, NEXT, FINISH} state_t;
endpackage

// File: rtl/tri_setup_sched_if.sv
// Host write port plus rasterizer read port of the triangle setup scheduler.
interface tri_setup_sched_if #(
  parameter int MAX_TRIS = 8,
  parameter int IDX_W    = $clog2(MAX_TRIS),
  parameter int CNT_W    = $clog2(MAX_TRIS + 1)
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [9:0]        wr_x0, wr_y0, wr_x1, wr_y1, wr_x2, wr_y2;
  logic [11:0]       wr_color;
  logic              commit;
  logic              clear;
  logic [IDX_W-1:0]  rd_idx;
  logic signed [10:0] rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2;
  logic signed [21:0] rd_c0, rd_c1, rd_c2;
  logic [11:0]       rd_color;
  logic [CNT_W-1:0]  tri_count;
  logic              active_valid;
  logic              setup_done;
  logic              frame_overrun;

  modport master (
    output wr_valid, wr_x0, wr_y0, wr_x1, wr_y1, wr_x2, wr_y2, wr_color,
           commit, clear, rd_idx,
    input  wr_ready, rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2,
           rd_c0, rd_c1, rd_c2, rd_color, tri_count, active_valid,
           setup_done, frame_overrun
  );

  modport slave (
    input  wr_valid, wr_x0, wr_y0, wr_x1, wr_y1, wr_x2, wr_y2, wr_color,
           commit, clear, rd_idx,
    output wr_ready, rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2,
           rd_c0, rd_c1, rd_c2, rd_color, tri_count, active_valid,
           setup_done, frame_overrun
  );
endinterface

// File: rtl/edge_setup_dp.sv
// Edge coefficient datapath: one shared 10x10 multiplier, used twice per edge
// (xa*yb latched into p, then xb*ya), plus the A/B/C subtractors.
module edge_setup_dp
  import raster_pkg::*;
(
  input  logic       clk,
  input  tri_t       tri_in,
  input  logic [1:0] edge_idx,
  input  logic       ld_p,
  output edge_t      res
);
  vertex_t            va, vb;
  logic [COORD_W-1:0] mul_x, mul_y;
  logic [19:0]        prod, p;

  // edge 0: v0->v1, edge 1: v1->v2, edge 2: v2->v0
  always_comb begin
    va = tri_in.v2;
    vb = tri_in.v0;
    case (edge_idx)
      2'd0: begin va = tri_in.v0; vb = tri_in.v1; end
      2'd1: begin va = tri_in.v1; vb = tri_in.v2; end
      default: ;
    endcase
  end

  assign mul_x = ld_p ? va.x : vb.x;
  assign mul_y = ld_p ? vb.y : va.y;
  assign prod  = {10'b0, mul_x} * {10'b0, mul_y};

  always_ff @(posedge clk)
    if (ld_p) p <= prod;

  always_comb begin
    res.a = $signed({1'b0, va.y}) - $signed({1'b0, vb.y});
    res.b = $signed({1'b0, vb.x}) - $signed({1'b0, va.x});
    res.c = $signed({2'b0, p}) - $signed({2'b0, prod});
  end
endmodule

// File: rtl/tri_setup_sched.sv
// Frame-synchronous triangle setup: stages host triangles and, on a committed
// frame, rebuilds the active edge table that the rasterizer reads by index.
module tri_setup_sched
  import raster_pkg::*;
#(
  parameter int MAX_TRIS = 8,
  parameter int IDX_W    = $clog2(MAX_TRIS),
  parameter int CNT_W    = $clog2(MAX_TRIS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  tri_setup_sched_if.slave bus
);
  state_t             state, state_nxt;
  tri_t               stg       [MAX_TRIS];
  edge_t              act_edge  [MAX_TRIS][3];
  logic [COLOR_W-1:0] act_color [MAX_TRIS];
  logic [CNT_W-1:0]   stg_count, tri_count;
  logic [IDX_W-1:0]   tri_idx;
  logic [1:0]         edge_idx;
  logic               commit_pending, active_valid, setup_done, frame_overrun;
  logic               start, ld_p, wr_edge, wr_col, finish, last_tri, wr_fire;
  edge_t              dp_res;

  assign bus.wr_ready = (state == IDLE) && (stg_count < CNT_W'(MAX_TRIS));
  assign wr_fire      = bus.wr_valid && bus.wr_ready && !bus.clear;
  assign last_tri     = (CNT_W'(tri_idx) + CNT_W'(1)) == stg_count;

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ld_p      = 1'b0;
    wr_edge   = 1'b0;
    wr_col    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (frame && commit_pending) begin
        start     = 1'b1;
        state_nxt = (stg_count == '0) ? FINISH : EDGE_P;
      end
      EDGE_P: begin
        ld_p      = 1'b1;
        state_nxt = EDGE_C;
      end
      EDGE_C: begin
        wr_edge   = 1'b1;
        state_nxt = (edge_idx == 2'd2) ? NEXT : EDGE_P;
      end
      NEXT: begin
        wr_col    = 1'b1;
        state_nxt = last_tri ? FINISH : EDGE_P;
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_count      <= '0;
      commit_pending <= 1'b0;
      tri_idx        <= '0;
      edge_idx       <= '0;
      tri_count      <= '0;
      active_valid   <= 1'b0;
      setup_done     <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      setup_done <= finish;
      if (frame && state != IDLE) frame_overrun <= 1'b1;
      // clear only acts while idle; a commit landing in FINISH survives
      if (state == IDLE && bus.clear) begin
        stg_count      <= '0;
        commit_pending <= 1'b0;
      end else begin
        if (wr_fire)         stg_count      <= stg_count + CNT_W'(1);
        if (bus.commit)      commit_pending <= 1'b1;
        else if (finish)     commit_pending <= 1'b0;
      end
      if (start) begin
        active_valid <= 1'b0;
        tri_idx      <= '0;
        edge_idx     <= '0;
      end
      if (wr_edge && edge_idx != 2'd2) edge_idx <= edge_idx + 2'd1;
      if (wr_col && !last_tri) begin
        tri_idx  <= tri_idx + IDX_W'(1);
        edge_idx <= '0;
      end
      if (finish) begin
        tri_count    <= stg_count;
        active_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      stg[stg_count[IDX_W-1:0]] <= tri_t'({bus.wr_x0, bus.wr_y0, bus.wr_x1, bus.wr_y1,
                                           bus.wr_x2, bus.wr_y2, bus.wr_color});
    if (wr_edge) act_edge[tri_idx][edge_idx] <= dp_res;
    if (wr_col)  act_color[tri_idx]          <= stg[tri_idx].color;
  end

  edge_setup_dp u_dp (
    .clk      (clk),
    .tri_in   (stg[tri_idx]),
    .edge_idx (edge_idx),
    .ld_p     (ld_p),
    .res      (dp_res)
  );

  assign bus.rd_a0         = act_edge[bus.rd_idx][0].a;
  assign bus.rd_b0         = act_edge[bus.rd_idx][0].b;
  assign bus.rd_c0         = act_edge[bus.rd_idx][0].c;
  assign bus.rd_a1         = act_edge[bus.rd_idx][1].a;
  assign bus.rd_b1         = act_edge[bus.rd_idx][1].b;
  assign bus.rd_c1         = act_edge[bus.rd_idx][1].c;
  assign bus.rd_a2         = act_edge[bus.rd_idx][2].a;
  assign bus.rd_b2         = act_edge[bus.rd_idx][2].b;
  assign bus.rd_c2         = act_edge[bus.rd_idx][2].c;
  assign bus.rd_color      = act_color[bus.rd_idx];
  assign bus.tri_count     = tri_count;
  assign bus.active_valid  = active_valid;
  assign bus.setup_done    = setup_done;
  assign bus.frame_overrun = frame_overrun;
endmodule

// File: tb/tb_tri_setup_sched.sv
// Scenario bench for tri_setup_sched: staged triangles are modelled on write,
// moved to a scoreboard on frame, and checked against the read port on setup_done.
module tb_tri_setup_sched;
  localparam int MAX_TRIS = 8;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame = 1'b0;

  tri_setup_sched_if #(.MAX_TRIS(MAX_TRIS)) bus ();

  tri_setup_sched #(.MAX_TRIS(MAX_TRIS)) dut (
    .clk   (clk),
    .rst   (rst),
    .frame (frame),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [143:0] stg_m [$];
  logic [143:0] exp_q [$];
  logic [143:0] act_m [MAX_TRIS];

  // {a0,b0,a1,b1,a2,b2,c0,c1,c2,color} derived from integer edge math
  function automatic logic [143:0] model_tri(input int x0, y0, x1, y1, x2, y2,
                                             input logic [11:0] col);
    int xs[3];
    int ys[3];
    logic [10:0] a[3];
    logic [10:0] b[3];
    logic [21:0] c[3];
    xs = '{x0, x1, x2};
    ys = '{y0, y1, y2};
    for (int e = 0; e < 3; e++) begin
      int nb;
      nb   = (e + 1) % 3;
      a[e] = 11'(ys[e] - ys[nb]);
      b[e] = 11'(xs[nb] - xs[e]);
      c[e] = 22'(xs[e] * ys[nb] - xs[nb] * ys[e]);
    end
    return {a[0], b[0], a[1], b[1], a[2], b[2], c[0], c[1], c[2], col};
  endfunction

  function automatic logic [143:0] observed();
    return {bus.rd_a0, bus.rd_b0, bus.rd_a1, bus.rd_b1, bus.rd_a2, bus.rd_b2,
            bus.rd_c0, bus.rd_c1, bus.rd_c2, bus.rd_color};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tri(input int x0, y0, x1, y1, x2, y2, input logic [11:0] col,
                           output bit acc);
    bus.wr_x0 = 10'(x0); bus.wr_y0 = 10'(y0);
    bus.wr_x1 = 10'(x1); bus.wr_y1 = 10'(y1);
    bus.wr_x2 = 10'(x2); bus.wr_y2 = 10'(y2);
    bus.wr_color = col;
    bus.wr_valid = 1'b1;
    acc = bus.wr_ready;
    tick();
    bus.wr_valid = 1'b0;
    if (acc) stg_m.push_back(model_tri(x0, y0, x1, y1, x2, y2, col));
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    stg_m.delete();
  endtask

  task automatic load_sb();
    foreach (stg_m[i]) exp_q.push_back(stg_m[i]);
  endtask

  // lat = cycles from the frame edge to setup_done, -1 if none within budget
  task automatic run_frame(input int ovr_at, output int lat);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == ovr_at) frame = 1'b1;
      tick();
      frame = 1'b0;
      if (bus.setup_done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic sb_drain();
    int i;
    logic [143:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.rd_idx = IDX_W'(i);
      #1;
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL entry%0d: got %h expected %h", i, observed(), e);
      end
      act_m[i] = e;
      i++;
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.tri_count, bus.active_valid, bus.setup_done, bus.frame_overrun, bus.wr_ready}
        !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d av=%b sd=%b ov=%b rdy=%b expected 0 0 0 0 1",
               bus.tri_count, bus.active_valid, bus.setup_done, bus.frame_overrun, bus.wr_ready);
    end
    run_frame(0, lat);
    n_checks++;
    if (lat !== -1) begin
      n_fail++;
      $display("FAIL frame_no_commit: setup_done after %0d cycles, expected none", lat);
    end
    n_checks++;
    if ({bus.tri_count, bus.active_valid} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_frame_state: got cnt=%0d av=%b expected 0 0",
               bus.tri_count, bus.active_valid);
    end
  endtask

  task automatic test_single();
    bit acc;
    int lat;
    write_tri(100, 100, 300, 100, 200, 300, 12'hF00, acc);
    pulse_commit();
    load_sb();
    run_frame(0, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL latency_single: got %0d expected 8", lat);
    end
    n_checks++;
    if ({bus.tri_count, bus.active_valid, bus.frame_overrun} !== {4'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_state: got cnt=%0d av=%b ov=%b expected 1 1 0",
               bus.tri_count, bus.active_valid, bus.frame_overrun);
    end
    bus.rd_idx = '0;
    #1;
    n_checks++;
    if ({bus.rd_a1, bus.rd_b1, bus.rd_c1} !== {-11'sd200, -11'sd100, 22'sd70000}) begin
      n_fail++;
      $display("FAIL edge1_single: got A=%0d B=%0d C=%0d expected -200 -100 70000",
               bus.rd_a1, bus.rd_b1, bus.rd_c1);
    end
    sb_drain();
    tick();
    n_checks++;
    if (bus.setup_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got %b expected 0", bus.setup_done);
    end
  endtask

  task automatic test_full();
    bit acc;
    int lat;
    pulse_clear();
    for (int t = 0; t < MAX_TRIS; t++)
      write_tri($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                12'($urandom_range(0, 4095)), acc);
    n_checks++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b expected 0", bus.wr_ready);
    end
    write_tri(1, 2, 3, 4, 5, 6, 12'h123, acc);
    n_checks++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL ninth_write: accepted=%b expected 0", acc);
    end
    pulse_commit();
    load_sb();
    run_frame(0, lat);
    n_checks++;
    if (lat !== 57) begin
      n_fail++;
      $display("FAIL latency_full: got %0d expected 57", lat);
    end
    n_checks++;
    if (bus.tri_count !== 4'd8) begin
      n_fail++;
      $display("FAIL full_count: got %0d expected 8", bus.tri_count);
    end
    sb_drain();
  endtask

  task automatic test_overrun();
    bit acc;
    int lat;
    pulse_clear();
    write_tri(100, 100, 300, 100, 200, 300, 12'hF00, acc);
    pulse_commit();
    load_sb();
    run_frame(3, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL latency_overrun: got %0d expected 8", lat);
    end
    n_checks++;
    if (bus.frame_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b expected 1", bus.frame_overrun);
    end
    sb_drain();
    tick(); tick(); tick();
    n_checks++;
    if (bus.frame_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b expected 1", bus.frame_overrun);
    end
  endtask

  task automatic test_clear();
    int lat;
    bus.wr_x0 = 10'd7; bus.wr_y0 = 10'd8; bus.wr_x1 = 10'd9;
    bus.wr_y1 = 10'd10; bus.wr_x2 = 10'd11; bus.wr_y2 = 10'd12;
    bus.wr_color = 12'h0F0;
    bus.wr_valid = 1'b1;
    bus.commit   = 1'b1;
    bus.clear    = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    bus.commit   = 1'b0;
    bus.clear    = 1'b0;
    stg_m.delete();
    run_frame(0, lat);
    n_checks++;
    if (lat !== -1) begin
      n_fail++;
      $display("FAIL clear_no_setup: setup_done after %0d cycles, expected none", lat);
    end
    bus.rd_idx = '0;
    #1;
    n_checks++;
    if ({bus.tri_count, bus.active_valid, observed()} !== {4'd1, 1'b1, act_m[0]}) begin
      n_fail++;
      $display("FAIL clear_retain: got cnt=%0d av=%b entry=%h expected 1 1 %h",
               bus.tri_count, bus.active_valid, observed(), act_m[0]);
    end
    pulse_commit();
    run_frame(0, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL latency_empty: got %0d expected 1", lat);
    end
    n_checks++;
    if ({bus.tri_count, bus.active_valid} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL empty_state: got cnt=%0d av=%b expected 0 1",
               bus.tri_count, bus.active_valid);
    end
  endtask

  task automatic test_extreme_rst();
    bit acc;
    int lat;
    write_tri(1023, 0, 0, 1023, 0, 0, 12'h0AB, acc);
    pulse_commit();
    load_sb();
    run_frame(0, lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL latency_extreme: got %0d expected 8", lat);
    end
    bus.rd_idx = '0;
    #1;
    n_checks++;
    if (bus.rd_c0 !== 22'sd1046529) begin
      n_fail++;
      $display("FAIL extreme_c0: got %0d expected 1046529", bus.rd_c0);
    end
    sb_drain();
    pulse_commit();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.tri_count, bus.active_valid, bus.setup_done, bus.frame_overrun, bus.wr_ready}
        !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midsetup_reset: got cnt=%0d av=%b sd=%b ov=%b rdy=%b expected 0 0 0 0 1",
               bus.tri_count, bus.active_valid, bus.setup_done, bus.frame_overrun, bus.wr_ready);
    end
    run_frame(0, lat);
    n_checks++;
    if (lat !== -1) begin
      n_fail++;
      $display("FAIL post_reset_frame: setup_done after %0d cycles, expected none", lat);
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_x0 = '0; bus.wr_y0 = '0; bus.wr_x1 = '0;
    bus.wr_y1 = '0; bus.wr_x2 = '0; bus.wr_y2 = '0;
    bus.wr_color = '0;
    bus.commit = 1'b0;
    bus.clear  = 1'b0;
    bus.rd_idx = '0;
    test_reset();
    test_single();
    test_full();
    test_overrun();
    test_clear();
    test_extreme_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
